// File: rtl/ysyx_wb_arb_pkg.sv
// rtl/ysyx_wb_arb_pkg.sv - shared types and constants for the writeback arbiter
package ysyx_wb_arb_pkg;

  localparam int WB_N_REQ = 3;
  localparam int WB_XLEN  = 32;
  localparam int WB_RF_AW = 5;
  localparam int WB_CNT_W = 16;

  // Requester slots; slot 0 wins first after reset
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;
  localparam int WB_REQ_CSR = 2;

  typedef struct packed {
    logic [WB_RF_AW-1:0] rd;
    logic [WB_XLEN-1:0]  data;
    logic [WB_XLEN-1:0]  pc;
    logic                ebreak;
  } wb_req_t;

  // Occupancy of the one-entry commit register
  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/ysyx_rr_pick.sv
// rtl/ysyx_rr_pick.sv - combinational round-robin priority picker
module ysyx_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  // Scan from ptr upward, wrapping, and take the first active request
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/ysyx_wb_arb.sv
// rtl/ysyx_wb_arb.sv - round-robin writeback arbiter, sole register-file writer
module ysyx_wb_arb
  import ysyx_wb_arb_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ,
  parameter int XLEN  = WB_XLEN,
  parameter int RF_AW = WB_RF_AW,
  parameter int CNT_W = WB_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*RF_AW-1:0] req_rd,
  input  logic [N_REQ*XLEN-1:0]  req_data,
  input  logic [N_REQ*XLEN-1:0]  req_pc,
  input  logic [N_REQ-1:0]       req_ebreak,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_ebreak,
  output logic                   rf_we,
  output logic [RF_AW-1:0]       rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_state_e        state;
  logic [PW-1:0]    rr_ptr;
  logic [RF_AW-1:0] ent_rd;
  logic [XLEN-1:0]  ent_data;
  logic [XLEN-1:0]  ent_pc;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             can_accept;
  logic             grant;
  logic             multi;

  ysyx_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign out_valid = (state == WB_FULL);

  // rst gates acceptance so nothing is granted while reset is held
  assign can_accept = rst & ~flush & (~out_valid | out_ready);
  assign req_ready  = can_accept ? pick_gnt : '0;
  assign grant      = can_accept & pick_any;
  assign multi      = ($countones(req_valid) > 1);

  // x0 writes are dropped but the commit handshake still completes
  assign rf_we    = out_valid & out_ready & ~flush & (ent_rd != '0);
  assign rf_waddr = ent_rd;
  assign rf_wdata = ent_data;
  assign out_pc   = ent_pc;

  // Entry register, occupancy state, rotation pointer and conflict counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WB_EMPTY;
      rr_ptr       <= '0;
      ent_rd       <= '0;
      ent_data     <= '0;
      ent_pc       <= '0;
      out_ebreak   <= 1'b0;
      conflict_cnt <= '0;
    end else if (flush) begin
      state <= WB_EMPTY;
    end else if (grant) begin
      state      <= WB_FULL;
      ent_rd     <= req_rd[pick_idx*RF_AW +: RF_AW];
      ent_data   <= req_data[pick_idx*XLEN +: XLEN];
      ent_pc     <= req_pc[pick_idx*XLEN +: XLEN];
      out_ebreak <= req_ebreak[pick_idx];
      rr_ptr     <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
      if (multi && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      state <= WB_EMPTY;
    end
  end

endmodule

// File: tb/tb_ysyx_wb_arb.sv
// tb/tb_ysyx_wb_arb.sv - directed self-checking bench for ysyx_wb_arb
module tb_ysyx_wb_arb;
  import ysyx_wb_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [95:0] req_pc;
  logic [2:0]  req_ebreak;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        out_ebreak;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;

  wb_req_t pl [3];

  int checks = 0;
  int errors = 0;

  assign req_rd     = {pl[2].rd, pl[1].rd, pl[0].rd};
  assign req_data   = {pl[2].data, pl[1].data, pl[0].data};
  assign req_pc     = {pl[2].pc, pl[1].pc, pl[0].pc};
  assign req_ebreak = {pl[2].ebreak, pl[1].ebreak, pl[0].ebreak};

  ysyx_wb_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_pc       (req_pc),
    .req_ebreak   (req_ebreak),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_ebreak   (out_ebreak),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; samples are taken 3 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_gnt;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = 3'b001;
    for (int i = 0; i < 3; i++) pl[i] = '0;
    pl[0] = '{rd: 5'd5, data: 32'hDEAD_BEEF, pc: 32'h8000_0000, ebreak: 1'b1};
    #3;
    check_eq("rst_ready", req_ready, 3'b000);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_cnt", conflict_cnt, 16'd0);
    tick();
    tick();

    // First grant and 1-cycle commit latency
    rst = 1'b1;
    #3;
    check_eq("t1_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    #3;
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_we", rf_we, 1'b1);
    check_eq("t1_waddr", rf_waddr, 5'd5);
    check_eq("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
    check_eq("t1_pc", out_pc, 32'h8000_0000);
    check_eq("t1_ebreak", out_ebreak, 1'b1);

    // Fresh reset so rotation starts from requester 0 with a zero counter
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      pl[i] = '{rd: 5'(10 + i), data: 32'h100 + 32'(i), pc: 32'h200 + 32'(i), ebreak: 1'b0};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      #3;
      exp_gnt = 3'b001 << (k % 3);
      check_eq("rr_gnt", req_ready, exp_gnt);
      if (k > 0) check_eq("rr_waddr", rf_waddr, 5'(10 + ((k - 1) % 3)));
    end
    tick();
    req_valid = 3'b000;
    #3;
    check_eq("rr_cnt", conflict_cnt, 16'd6);
    check_eq("rr_last", rf_waddr, 5'd12);
    check_eq("rr_we", rf_we, 1'b1);

    // Stall: entry holds while out_ready is low, then same-cycle regrant
    tick();
    pl[0] = '{rd: 5'd7, data: 32'h77, pc: 32'h700, ebreak: 1'b0};
    pl[1] = '{rd: 5'd9, data: 32'h99, pc: 32'h900, ebreak: 1'b0};
    req_valid = 3'b001;
    out_ready = 1'b0;
    #3;
    check_eq("st_grant0", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #3;
      check_eq("st_ready", req_ready, 3'b000);
      check_eq("st_valid", out_valid, 1'b1);
      check_eq("st_waddr", rf_waddr, 5'd7);
      check_eq("st_wdata", rf_wdata, 32'h77);
      check_eq("st_we", rf_we, 1'b0);
    end
    tick();
    out_ready = 1'b1;
    #3;
    check_eq("st_regrant", req_ready, 3'b010);
    check_eq("st_commit", rf_we, 1'b1);
    tick();
    req_valid = 3'b000;
    #3;
    check_eq("st_new_waddr", rf_waddr, 5'd9);
    check_eq("st_new_wdata", rf_wdata, 32'h99);

    // x0 destination: handshake completes without a register write
    tick();
    pl[0] = '{rd: 5'd0, data: 32'h1234, pc: 32'h300, ebreak: 1'b0};
    req_valid = 3'b001;
    #3;
    check_eq("x0_grant", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    #3;
    check_eq("x0_valid", out_valid, 1'b1);
    check_eq("x0_we", rf_we, 1'b0);
    check_eq("x0_wdata", rf_wdata, 32'h1234);
    tick();
    #3;
    check_eq("x0_done", out_valid, 1'b0);

    // Flush with a held entry: no write, no grant, pointer kept at 2
    pl[1] = '{rd: 5'd3, data: 32'h33, pc: 32'h330, ebreak: 1'b0};
    pl[2] = '{rd: 5'd4, data: 32'h44, pc: 32'h440, ebreak: 1'b1};
    tick();
    req_valid = 3'b010;
    out_ready = 1'b0;
    #3;
    check_eq("fl_pre_grant", req_ready, 3'b010);
    tick();
    req_valid = 3'b100;
    out_ready = 1'b1;
    flush     = 1'b1;
    #3;
    check_eq("fl_ready", req_ready, 3'b000);
    check_eq("fl_we", rf_we, 1'b0);
    check_eq("fl_valid_now", out_valid, 1'b1);
    tick();
    flush     = 1'b0;
    req_valid = 3'b111;
    #3;
    check_eq("fl_valid_next", out_valid, 1'b0);
    check_eq("fl_ptr", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    out_ready = 1'b0;
    #3;
    check_eq("fl_cnt", conflict_cnt, 16'd7);
    check_eq("fl_waddr", rf_waddr, 5'd4);
    check_eq("fl_ebreak", out_ebreak, 1'b1);

    // Asynchronous reset mid-stream with a held entry
    req_valid = 3'b111;
    #1;
    rst = 1'b0;
    #1;
    check_eq("ar_valid", out_valid, 1'b0);
    check_eq("ar_ready", req_ready, 3'b000);
    check_eq("ar_we", rf_we, 1'b0);
    check_eq("ar_cnt", conflict_cnt, 16'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_wb_arb.md
Name: ysyx_wb_arb

Overview:
- Shares the single register-file write port and the writeback commit path between N result producers (ALU/EXU, LSU load return, CSR/MUL).
- Round-robin arbitration into a one-entry output register. That register drives the rf write strobe and the valid/ready commit handshake into the writeback stage.
- Sits between the execute-side producers and the writeback stage. It is the only writer of the register file.

Parameters:
- N_REQ, 3, number of requesters; index 0 is the highest priority after reset.
- XLEN, 32, data and pc width.
- RF_AW, 5, register address width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i holds a result.
- req_ready  out  N_REQ  grant/accept strobe for requester i.
- req_rd  in  N_REQ*RF_AW  destination register per requester.
- req_data  in  N_REQ*XLEN  write data per requester.
- req_pc  in  N_REQ*XLEN  instruction pc per requester.
- req_ebreak  in  N_REQ  instruction is ebreak.
- flush  in  1  drop the held entry; accept nothing this cycle.
- out_valid  out  1  commit entry valid, toward writeback.
- out_ready  in  1  writeback accepts the entry.
- out_pc  out  XLEN  pc of the committing instruction.
- out_ebreak  out  1  committing instruction is ebreak.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RF_AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- conflict_cnt  out  CNT_W  number of cycles with more than one req_valid while a grant occurred; saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_ebreak=0, entry rd/data/pc=0.
  - rr_ptr=0, conflict_cnt=0.
  - req_ready=0 while rst is low.
- Accept condition:
  - can_accept = !flush & (!out_valid | out_ready).
  - When can_accept, exactly one req_ready is high: the first i with req_valid[i], searching from rr_ptr upward modulo N_REQ.
  - Otherwise all req_ready are 0.
  - req_ready is combinational from req_valid, rr_ptr and the output-register state.
- Grant (req_valid[g] & req_ready[g]):
  - The entry register loads rd/data/pc/ebreak of g on the clock edge.
  - out_valid=1 next cycle (1-cycle latency).
  - rr_ptr <= (g+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- Throughput:
  - One commit per cycle. A simultaneous out handshake and new grant replaces the entry with no bubble.
  - With out_ready=0 and out_valid=1, the entry holds and no requester is accepted.
- Register-file write:
  - rf_we = out_valid & out_ready & (rd != 0).
  - rf_waddr and rf_wdata come straight from the entry register.
  - Writes to x0 are suppressed, but the commit still completes.
- Output clear: on an out handshake with no new grant, out_valid <= 0.
- flush:
  - Takes priority over everything.
  - out_valid <= 0 next cycle, rf_we=0 this cycle, no grant, rr_ptr and conflict_cnt unchanged.
- Fairness:
  - A requester holding req_valid is granted within N_REQ grants.
  - Requesters must hold req_valid and payload stable until accepted; the block does not check this.
- conflict_cnt increments on a grant cycle where popcount(req_valid) > 1. It sticks at 2^CNT_W-1.
- Reset asserted mid-operation drops any held entry immediately; no rf write is issued.
- Two-state view of the output register: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on grant.
  - FULL -> FULL on handshake plus grant, or on stall.
  - FULL -> EMPTY on handshake without grant, or on flush.

Decomposition:
- Shared package holds:
  - wb_req_t struct {rd, data, pc, ebreak}.
  - N_REQ/RF_AW defaults.
  - Requester index constants (WB_REQ_ALU=0, WB_REQ_LSU=1, WB_REQ_CSR=2).
- One sub-module, ysyx_rr_pick: combinational round-robin priority picker. Inputs req vector and ptr; outputs one-hot grant and the grant index. It is reusable by the bus arbiter.

Test Plan:
- Reset release, req_valid=3'b001, rd=5, data=0xDEADBEEF, out_ready=1 -> req_ready[0] same cycle; next cycle out_valid=1, rf_we=1, waddr=5, wdata=0xDEADBEEF.
- req_valid=3'b111 held for 6 cycles, out_ready=1 -> grant order 0,1,2,0,1,2; conflict_cnt=6.
- Entry held with out_ready=0 for 4 cycles, req_valid=3'b010 -> req_ready=0, out fields stable, rf_we=0; on out_ready=1, requester 1 is granted in the same cycle.
- Commit with rd=0, data=0x1234 -> out_valid/out_ready handshake completes, rf_we=0.
- flush asserted while out_valid=1 and req_valid=3'b100 -> no rf_we, no grant, out_valid=0 next cycle, rr_ptr unchanged.
- rst driven low mid-stream with out_valid=1 -> out_valid=0 and req_ready=0 immediately (before the next clk edge), conflict_cnt=0.
